// File: rtl/acc_store_buffer.sv
// -----------------------------------------------------------------------------
// acc_store_buffer
//
// Store path for the accumulator. Each st_ac strobe captures {addr_in, ac_in}
// into a small FIFO. The FIFO head is drained to data memory over a registered
// req/ack write handshake, so the controller never stalls on memory.
//
// Ports
//   clk       in   rising-edge system clock
//   rst       in   asynchronous reset, active-high
//   st_ac     in   store strobe; pushes {addr_in, ac_in} when not full
//   ac_in     in   accumulator value
//   addr_in   in   store target address
//   full      out  count == DEPTH
//   empty     out  count == 0
//   count     out  entries held, 0..DEPTH
//   mem_wr    out  write request (registered)
//   mem_addr  out  head entry address, valid while mem_wr
//   mem_data  out  head entry data, valid while mem_wr
//   mem_ack   in   memory accepted the current write at this edge
//
// Optional feature (macro STORE_OVF_EN)
//   ovf       out  sticky flag: a store arrived while full
//   clr_ovf   in   clears ovf (a same-edge overflow wins)
// Without STORE_OVF_EN these ports are absent and overflowed stores are
// dropped silently.
// -----------------------------------------------------------------------------
module acc_store_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       st_ac,
  input  logic [DATA_WIDTH-1:0]      ac_in,
  input  logic [ADDR_WIDTH-1:0]      addr_in,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       mem_wr,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_data,
  input  logic                       mem_ack
`ifdef STORE_OVF_EN
  ,
  output logic                       ovf,
  input  logic                       clr_ovf
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, WRITE} state_t;

  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      rd_ptr_nx;
  logic [CNT_W-1:0]      cnt;
  state_t                state;
  logic                  push;
  logic                  pop;

  assign full      = (cnt == CNT_W'(DEPTH));
  assign empty     = (cnt == '0);
  assign count     = cnt;
  // A store while full is dropped even when a pop frees a slot on the same edge.
  assign push      = st_ac && !full;
  assign pop       = (state == WRITE) && mem_ack;
  assign rd_ptr_nx = rd_ptr + PTR_W'(1);

  // Entry storage: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr] <= ac_in;
      addr_q[wr_ptr] <= addr_in;
    end
  end

  // Pointers, occupancy and write-handshake FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      state    <= IDLE;
      mem_wr   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr_nx;

      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase

      case (state)
        IDLE: begin
          // A store into the empty FIFO bypasses storage onto the write port so
          // the request rises in the cycle right after the strobe.
          if (cnt != '0) begin
            state    <= WRITE;
            mem_wr   <= 1'b1;
            mem_addr <= addr_q[rd_ptr];
            mem_data <= data_q[rd_ptr];
          end else if (push) begin
            state    <= WRITE;
            mem_wr   <= 1'b1;
            mem_addr <= addr_in;
            mem_data <= ac_in;
          end
        end
        WRITE: begin
          if (mem_ack) begin
            if (cnt > CNT_W'(1)) begin
              // Next head is already stored behind the one just accepted.
              mem_addr <= addr_q[rd_ptr_nx];
              mem_data <= data_q[rd_ptr_nx];
            end else if (push) begin
              // Last entry leaves as a new one arrives: the new one is the head.
              mem_addr <= addr_in;
              mem_data <= ac_in;
            end else begin
              state  <= IDLE;
              mem_wr <= 1'b0;
            end
          end
        end
        default: begin
          state  <= IDLE;
          mem_wr <= 1'b0;
        end
      endcase
    end
  end

`ifdef STORE_OVF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (st_ac && full) begin
      ovf <= 1'b1;
    end else if (clr_ovf) begin
      ovf <= 1'b0;
    end
  end
`endif

endmodule
